if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: pipelined imem requests, in-order tag FIFO, 2-entry queue, IF/ID register.
// Define IF_PERF_CNT_EN to add the saturating discard_count output.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] current_pc_out,
  output logic [31:0] pc_plus_4_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] discard_count
`endif
);

  logic [31:0]      pc_q, pc_d;
  logic [1:0]       out_q, out_d;
  logic [1:0]       disc_q, disc_d;
  logic [1:0][31:0] tag_q, tag_d;
  logic [1:0][31:0] qi_q, qi_d;
  logic [1:0][31:0] qp_q, qp_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic             vld_q, vld_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      cpc_q, cpc_d;
  logic [31:0]      pc4_q, pc4_d;

  logic [2:0] pending;
  logic [1:0] tcnt, qc;
  logic       fire, rsp, drop, push, load, pop;
  logic       unused_tgt;

  assign unused_tgt = ^branch_target[1:0];

  always_comb begin
    pending  = {1'b0, out_q} - {1'b0, disc_q} + {1'b0, qcnt_q};
    imem_req = !reset && !branch_taken
             && (out_q < 2'd2) && (pending < 3'd2);
    imem_addr = pc_q;
    fire = imem_req && imem_gnt;
    rsp  = imem_rvalid && !reset;
    drop = rsp && (branch_taken || disc_q != 2'd0);
    push = rsp && !drop;
    load = !stall || !vld_q;
    pop  = load && qcnt_q != 2'd0;

    pc_d = fire ? pc_q + 32'd4 : pc_q;

    // tag FIFO occupancy always equals the outstanding count
    tag_d = tag_q;
    tcnt  = out_q;
    if (rsp) begin
      tag_d[0] = tag_q[1];
      tcnt     = out_q - 2'd1;
    end
    if (fire) tag_d[tcnt[0]] = pc_q;
    out_d = tcnt + {1'b0, fire};

    disc_d = disc_q;
    if (drop && !branch_taken) disc_d = disc_q - 2'd1;

    qi_d = qi_q;
    qp_d = qp_q;
    qc   = qcnt_q;
    if (pop) begin
      qi_d[0] = qi_q[1];
      qp_d[0] = qp_q[1];
      qc      = qcnt_q - 2'd1;
    end
    if (push) begin
      qi_d[qc[0]] = imem_rdata;
      qp_d[qc[0]] = tag_q[0];
      qc          = qc + 2'd1;
    end
    qcnt_d = qc;

    vld_d   = vld_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    pc4_d   = pc4_q;
    if (load) begin
      if (qcnt_q != 2'd0) begin
        vld_d   = 1'b1;
        instr_d = qi_q[0];
        cpc_d   = qp_q[0];
        pc4_d   = qp_q[0] + 32'd4;
      end else begin
        vld_d = 1'b0;
      end
    end

    // redirect wins over stall, queue loads and responses
    if (branch_taken) begin
      pc_d   = {branch_target[31:2], 2'b00};
      disc_d = out_q - {1'b0, rsp};
      qcnt_d = 2'd0;
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      tag_q   <= '0;
      qi_q    <= '0;
      qp_q    <= '0;
      qcnt_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      cpc_q   <= '0;
      pc4_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      tag_q   <= tag_d;
      qi_q    <= qi_d;
      qp_q    <= qp_d;
      qcnt_q  <= qcnt_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign if_valid       = vld_q;
  assign instruction    = instr_q;
  assign current_pc_out = cpc_q;
  assign pc_plus_4_out  = pc4_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (drop && dcnt_q != 32'hFFFF_FFFF) dcnt_d = dcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_d;
  end

  assign discard_count = dcnt_q;
`endif

endmodule
